// File: rtl/ser_link_pkg.sv
// Shared definitions for the 8:1 select-counter serial link.
// The transmitter and receiver both use bit_pos so that they order bits the same way.
package ser_link_pkg;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned SEL_W  = 3;

  localparam logic [SEL_W-1:0] SEL_LAST = 3'd7;

  // Holding register for an assembled word and its valid flag
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              valid;
  } word_t;

  // Maps a select value to a word bit position.
  // With lsb_first, select 0 lands in bit 0; otherwise select 0 lands in bit 7.
  function automatic logic [SEL_W-1:0] bit_pos(input logic [SEL_W-1:0] sel,
                                               input logic             lsb_first);
    return lsb_first ? sel : SEL_LAST - sel;
  endfunction

endpackage

// File: rtl/demux8_deser_if.sv
// Serial input and parallel output bundle for demux8_deser.
//   master : the link side, which drives din/din_valid/frame/dout_ready
//   slave  : the deserializer, which drives dout/dout_valid/sel/overrun
interface demux8_deser_if;
  import ser_link_pkg::*;

  logic              din;
  logic              din_valid;
  logic              frame;
  logic [WORD_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic [SEL_W-1:0]  sel;
  logic              overrun;

  modport master (
    output din, din_valid, frame, dout_ready,
    input  dout, dout_valid, sel, overrun
  );

  modport slave (
    input  din, din_valid, frame, dout_ready,
    output dout, dout_valid, sel, overrun
  );

endinterface

// File: rtl/demux1_8.sv
// Combinational 1:8 demux.
//   din    : serial bit
//   en     : write strobe
//   sel    : target bit position
//   we_c   : one-hot write enable, all zero when en is low
//   data_c : din replicated across every position
module demux1_8
  import ser_link_pkg::*;
(
  input  logic              din,
  input  logic              en,
  input  logic [SEL_W-1:0]  sel,
  output logic [WORD_W-1:0] we_c,
  output logic [WORD_W-1:0] data_c
);

  // One-hot enable decode
  always_comb begin
    we_c = '0;
    if (en) begin
      we_c[sel] = 1'b1;
    end
  end

  assign data_c = {WORD_W{din}};

endmodule

// File: rtl/demux8_deser.sv
// Serial-to-parallel deserializer. It collects 8 bits, one per din_valid cycle, into a word.
// When the last bit arrives it presents the word with a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of demux8_deser_if
//                (din, din_valid, frame, dout_ready in; dout, dout_valid, sel, overrun out)
//   LSB_FIRST  : 1 = first bit goes to dout[0], 0 = first bit goes to dout[7]
module demux8_deser
  import ser_link_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
)(
  input  logic           clk,
  input  logic           rst_n,
  demux8_deser_if.slave  bus
);

  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  eff_sel;
  logic [SEL_W-1:0]  pos;
  logic [WORD_W-1:0] part_q, part_d;
  logic [WORD_W-1:0] we;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] merged;
  word_t             out_q, out_d;
  logic              ovr_q, ovr_d;
  logic              complete;

  // frame forces alignment, so the current bit acts as select 0
  assign eff_sel = bus.frame ? '0 : sel_q;
  assign pos     = bit_pos(eff_sel, LSB_FIRST);

  demux1_8 u_demux (
    .din    (bus.din),
    .en     (bus.din_valid),
    .sel    (pos),
    .we_c   (we),
    .data_c (wdata)
  );

  // Next-state logic for the select counter, partial word and output register
  always_comb begin
    sel_d  = sel_q;
    part_d = part_q;
    out_d  = out_q;
    ovr_d  = 1'b0;

    complete = bus.din_valid && !bus.frame && (sel_q == SEL_LAST);
    // frame discards the partial word before the current bit is merged in
    merged   = ((bus.frame ? '0 : part_q) & ~we) | (wdata & we);

    if (bus.din_valid) begin
      sel_d  = eff_sel + SEL_W'(1);
      part_d = complete ? '0 : merged;
    end

    if (complete) begin
      out_d.data  = merged;
      out_d.valid = 1'b1;
      // A word is lost only when nothing consumes the old one at this edge
      ovr_d       = out_q.valid && !bus.dout_ready;
    end else if (bus.dout_ready) begin
      out_d.valid = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      part_q <= '0;
      out_q  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      part_q <= part_d;
      out_q  <= out_d;
      ovr_q  <= ovr_d;
    end
  end

  assign bus.dout       = out_q.data;
  assign bus.dout_valid = out_q.valid;
  assign bus.sel        = sel_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_demux8_deser.sv
// Bench for demux8_deser. The same serial stimulus drives an LSB-first instance (a) and an
// MSB-first instance (b). Expected words are queued when a stream is sent. A monitor pops
// the queue and compares each word at the edge where the bench consumes it.
module tb_demux8_deser;
  import ser_link_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic din, din_valid, frame, dout_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  demux8_deser_if if_a ();
  demux8_deser_if if_b ();

  assign if_a.din        = din;
  assign if_a.din_valid  = din_valid;
  assign if_a.frame      = frame;
  assign if_a.dout_ready = dout_ready;
  assign if_b.din        = din;
  assign if_b.din_valid  = din_valid;
  assign if_b.frame      = frame;
  assign if_b.dout_ready = dout_ready;

  demux8_deser #(.LSB_FIRST(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  demux8_deser #(.LSB_FIRST(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors. They sample at the negedge, before the edge that consumes the word.
  always @(negedge clk) begin
    if (rst_n && if_a.dout_valid && if_a.dout_ready) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_a: unexpected word 0x%0h", if_a.dout);
      end else begin
        chk("sb_a", 32'(if_a.dout), 32'(q_a.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if_b.dout_valid && if_b.dout_ready) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_b: unexpected word 0x%0h", if_b.dout);
      end else begin
        chk("sb_b", 32'(if_b.dout), 32'(q_b.pop_front()));
      end
    end
  end

  // Each task starts and ends 1 time unit after a rising edge
  task automatic send_bit(input logic b, input logic fr);
    din = b; din_valid = 1'b1; frame = fr;
    @(posedge clk); #1;
    din_valid = 1'b0; frame = 1'b0; din = 1'b0;
  endtask

  // bits[0] is sent first. Gap cycles follow each bit, and sel is checked after each bit and
  // after each gap. rdy_last raises dout_ready on the completing edge.
  task automatic send_stream(input logic [7:0] bits, input int gap, input bit rdy_last);
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && rdy_last) dout_ready = 1'b1;
      send_bit(bits[i], 1'b0);
      dout_ready = 1'b0;
      chk("sel_a", 32'(if_a.sel), 32'((i + 1) % 8));
      chk("sel_b", 32'(if_b.sel), 32'((i + 1) % 8));
      if (gap > 0) begin
        repeat (gap) begin @(posedge clk); #1; end
        chk("sel_gap_a", 32'(if_a.sel), 32'((i + 1) % 8));
        chk("sel_gap_b", 32'(if_b.sel), 32'((i + 1) % 8));
      end
    end
  endtask

  task automatic consume();
    dout_ready = 1'b1;
    @(posedge clk); #1;
    dout_ready = 1'b0;
    chk("consumed_valid_a", 32'(if_a.dout_valid), 32'd0);
    chk("consumed_valid_b", 32'(if_b.dout_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; frame = 1'b0; dout_ready = 1'b0;
    #1;
    chk("rst_dout", 32'(if_a.dout), 32'h00);
    chk("rst_valid", 32'(if_a.dout_valid), 32'd0);
    chk("rst_sel", 32'(if_a.sel), 32'd0);
    chk("rst_overrun", 32'(if_a.overrun), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic word: 1,1,0,1,1,1,0,1 gives BB on a and DD on b
    q_a.push_back(8'hBB); q_b.push_back(8'hDD);
    send_stream(8'hBB, 0, 1'b0);
    chk("w1_dout_a", 32'(if_a.dout), 32'hBB);
    chk("w1_dout_b", 32'(if_b.dout), 32'hDD);
    chk("w1_valid_a", 32'(if_a.dout_valid), 32'd1);
    chk("w1_valid_b", 32'(if_b.dout_valid), 32'd1);
    chk("w1_ovr", 32'(if_a.overrun), 32'd0);
    consume();

    // Same stream with 3-cycle gaps between bits
    q_a.push_back(8'hBB); q_b.push_back(8'hDD);
    send_stream(8'hBB, 3, 1'b0);
    chk("gap_valid_a", 32'(if_a.dout_valid), 32'd1);
    consume();

    // Back to back with no consumer: the second word overwrites the first
    q_a.push_back(8'h5A); q_b.push_back(8'h5A);
    send_stream(8'hBB, 0, 1'b0);
    chk("ovr_first_a", 32'(if_a.overrun), 32'd0);
    send_stream(8'h5A, 0, 1'b0);
    chk("ovr_pulse_a", 32'(if_a.overrun), 32'd1);
    chk("ovr_pulse_b", 32'(if_b.overrun), 32'd1);
    chk("ovr_dout_a", 32'(if_a.dout), 32'h5A);
    chk("ovr_valid_a", 32'(if_a.dout_valid), 32'd1);
    @(posedge clk); #1;
    chk("ovr_drop_a", 32'(if_a.overrun), 32'd0);
    chk("ovr_hold_valid_a", 32'(if_a.dout_valid), 32'd1);
    consume();

    // Back to back, consumed on the second completion edge
    q_a.push_back(8'hBB); q_b.push_back(8'hDD);
    q_a.push_back(8'h5A); q_b.push_back(8'h5A);
    send_stream(8'hBB, 0, 1'b0);
    send_stream(8'h5A, 0, 1'b1);
    chk("b2b_valid_a", 32'(if_a.dout_valid), 32'd1);
    chk("b2b_valid_b", 32'(if_b.dout_valid), 32'd1);
    chk("b2b_ovr_a", 32'(if_a.overrun), 32'd0);
    chk("b2b_dout_a", 32'(if_a.dout), 32'h5A);
    @(posedge clk); #1;
    chk("b2b_ovr_late_a", 32'(if_a.overrun), 32'd0);
    consume();

    // Realignment: three bits are discarded, then frame+1 and seven zeros
    q_a.push_back(8'h01); q_b.push_back(8'h80);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    chk("pre_frame_sel", 32'(if_a.sel), 32'd3);
    frame = 1'b1; @(posedge clk); #1; frame = 1'b0;
    chk("ignored_frame_sel", 32'(if_a.sel), 32'd3);
    send_bit(1'b1, 1'b1);
    chk("frame_sel_a", 32'(if_a.sel), 32'd1);
    for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
    chk("frame_dout_a", 32'(if_a.dout), 32'h01);
    chk("frame_dout_b", 32'(if_b.dout), 32'h80);
    chk("frame_sel_end", 32'(if_a.sel), 32'd0);
    consume();

    // Asynchronous reset mid-word with an unconsumed word pending
    send_stream(8'hBB, 0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    chk("pre_rst_sel", 32'(if_a.sel), 32'd5);
    chk("pre_rst_valid", 32'(if_a.dout_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout_a", 32'(if_a.dout), 32'h00);
    chk("arst_valid_a", 32'(if_a.dout_valid), 32'd0);
    chk("arst_sel_a", 32'(if_a.sel), 32'd0);
    chk("arst_dout_b", 32'(if_b.dout), 32'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    q_a.push_back(8'hBB); q_b.push_back(8'hDD);
    send_stream(8'hBB, 0, 1'b0);
    chk("post_rst_dout_a", 32'(if_a.dout), 32'hBB);
    consume();

    chk("q_a_empty", 32'(q_a.size()), 32'd0);
    chk("q_b_empty", 32'(q_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux8_deser.md
# demux8_deser

Serial-to-parallel deserializer: the receiving end of the 8:1 select-counter serial link. One bit per valid cycle arrives on `din`. An internal 3-bit select counter steers each bit into word position 0..7 through a 1:8 demux. When the eighth bit lands, the assembled byte is presented on `dout` with a valid/ready handshake. It sits on the far side of the link and rebuilds bytes that the transmitter emits LSB-first, with select 0 first.

## Interface
- `LSB_FIRST`, default 1: 1 = first bit after alignment goes to `dout[0]`; 0 = first bit goes to `dout[7]`.
- `clk`, input, 1: single clock, rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `din`, input, 1: serial data bit.
- `din_valid`, input, 1: `din` is sampled on this edge.
- `frame`, input, 1: word-alignment strobe; qualified by `din_valid`.
- `dout`, output, 8: assembled word.
- `dout_valid`, output, 1: `dout` holds an unconsumed word.
- `dout_ready`, input, 1: consumer accepts `dout` this edge.
- `sel`, output, 3: current select / bit position of the next bit.
- `overrun`, output, 1: one-cycle pulse when an unconsumed word is overwritten.

## Operation
- Reset (async assert, sync-safe deassert at the next edge): `sel`=0, partial register=8'h00, `dout`=8'h00, `dout_valid`=0, `overrun`=0.
- Bit position: `sel` when `LSB_FIRST`=1; `7-sel` otherwise.
- `din_valid`=1, `frame`=0:
  - `din` is written into the partial register at the bit position.
  - `sel` increments mod 8, wrapping 7→0.
- `din_valid`=1, `frame`=1:
  - The partial word is discarded; the partial register is cleared to 0.
  - `din` is written at position for `sel`=0, and `sel` becomes 1.
- `frame` with `din_valid`=0 is ignored.
- `din_valid`=0: no state change in `sel` or the partial register.
- Word completion is any accepted bit with effective select 7, i.e. `sel`==7 and `frame`=0.
  - At that edge, `dout` loads the partial register merged with the current bit.
  - `dout_valid` is set, and the partial register clears to 0.
- Handshake:
  - `dout_valid` and `dout` hold stable until an edge with `dout_ready`=1.
  - That edge clears `dout_valid` unless a completion occurs at the same edge.
- Simultaneous completion and `dout_ready`=1 with `dout_valid`=1: the old word is consumed, the new word loads, `dout_valid` stays 1, and `overrun`=0.
- Completion while `dout_valid`=1 and `dout_ready`=0: the new word overwrites `dout`, `dout_valid` stays 1, and `overrun`=1 for exactly one cycle.
- `dout_ready` while `dout_valid`=0: no effect.
- Reset mid-word: the partial word is lost and all outputs return to reset values immediately, without waiting for a clock edge.

## Timing
- `din` and `din_valid` are sampled at the rising edge. Throughput is one bit per cycle, one word per 8 valid cycles.
- Latency: `dout`/`dout_valid` are updated at the same edge that samples bit 8 and are visible in the following cycle.
- `sel` is registered and reflects the position of the next bit.
- `overrun` is registered, asserted the cycle after the offending edge, and deasserts after one cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `ser_link_pkg`:
  - `WORD_W`=8.
  - `SEL_W`=3.
  - `SEL_LAST`=3'd7.
  - Bit-position mapping function; it is shared with the transmitter so both ends agree on ordering.
- Sub-module `demux1_8` (combinational): inputs `din`, `en`, and 3-bit select; output 8-bit one-hot write-enable plus data. Instantiated once.
- Top level: select counter, partial register, output register, and handshake/overrun logic.

## Test plan
- Reset, then 8 valid bits 1,1,0,1,1,1,0,1 (`LSB_FIRST`=1) → after the 8th edge, `dout`=8'hBB, `dout_valid`=1, `sel`=0. `dout_ready`=1 on the next edge → `dout_valid`=0.
- Same stream with `LSB_FIRST`=0 → `dout`=8'hDD. `din_valid` gaps of 3 cycles between bits → the same result, with `sel` frozen during gaps.
- Two back-to-back words 8'hBB then 8'h5A with `dout_ready` held 0 → `dout`=8'h5A, `overrun` pulses 1 cycle, `dout_valid` stays 1.
- Two back-to-back words with `dout_ready`=1 at the second completion edge → `dout`=8'h5A, `dout_valid` continuously 1, `overrun` stays 0.
- 3 bits sent, then `frame`+`din_valid` with `din`=1 followed by 7 bits 0 → the first 3 bits are discarded and `dout`=8'h01.
- `rst_n` pulsed low asynchronously between edges after 5 bits → outputs are immediately 0 and `sel`=0. A fresh 8 bits 8'hBB → `dout`=8'hBB.
